// File: rtl/uart_cmd_pkg.sv
// Shared constants for the UART command decoder: byte/counter widths, FSM
// state encodings and the default ON/OFF code bases, plus a helper that
// expands a base code into a packed per-channel code table (base + k).
package uart_cmd_pkg;

  localparam int BYTE_W      = 8;
  localparam int DROP_W      = 8;
  // Widest code table any legal configuration can need: 16 channels x 64 bits.
  localparam int CODES_MAX_W = 16 * 64;

  // FSM states, kept as plain constants for compatibility with older tools.
  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_MATCH   = 1'b1;

  localparam logic [31:0] DEF_ON_CODE  = 32'h00B835F2;
  localparam logic [31:0] DEF_OFF_CODE = 32'hC0C0FFEE;

  // Channel k gets (base + k), packed with channel 0 in the least significant
  // word_bits bits. Bits above channels*word_bits are left zero.
  function automatic logic [CODES_MAX_W-1:0] make_codes(input logic [63:0] base,
                                                        input int          channels,
                                                        input int          word_bits);
    logic [CODES_MAX_W-1:0] codes;
    logic [63:0]            val;
    logic [9:0]             idx;
    codes = '0;
    for (int k = 0; k < 16; k++) begin
      val = base + 64'(k);
      for (int b = 0; b < 64; b++) begin
        if (k < channels && b < word_bits) begin
          idx        = 10'(k * word_bits + b);
          codes[idx] = val[0];
        end
        val = val >> 1;
      end
    end
    return codes;
  endfunction

endpackage

// File: rtl/uart_cmd_fifo.sv
// Purpose: generic synchronous FIFO with registered full/empty flags.
// Latency: a pushed entry is visible on out_dat/out_vld the cycle after push.
// Backpressure: in_rdy = !full (registered); pop permitted while full, push is not.
//
// Ports:
//   clk_i, reset_ni        clock, synchronous active-low reset (empties FIFO)
//   in_dat/in_vld/in_rdy   write side, transfer when in_vld & in_rdy
//   out_dat/out_vld/out_rdy read side, transfer when out_vld & out_rdy;
//                          out_dat holds steady until the entry is popped
module uart_cmd_fifo #(
  parameter int depth_p = 8,
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset_ni,
  input  logic [width_p-1:0] in_dat,
  input  logic               in_vld,
  output logic               in_rdy,
  output logic [width_p-1:0] out_dat,
  output logic               out_vld,
  input  logic               out_rdy
);

  localparam int PTR_W = $clog2(depth_p);
  localparam int CNT_W = $clog2(depth_p + 1);

  logic [width_p-1:0] mem [depth_p];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic [CNT_W-1:0]   count_nxt;
  logic               full_r;
  logic               empty_r;
  logic               push;
  logic               pop;

  assign push    = in_vld && !full_r;
  assign pop     = out_rdy && !empty_r;
  assign in_rdy  = !full_r;
  assign out_vld = !empty_r;
  // Reads never alias a pending write: writes only land on free slots.
  assign out_dat = mem[rd_ptr_r];

  always_comb begin
    count_nxt = count_r;
    if (push && !pop) begin
      count_nxt = count_r + CNT_W'(1);
    end else if (pop && !push) begin
      count_nxt = count_r - CNT_W'(1);
    end
  end

  // Depth is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nxt;
      full_r  <= (count_nxt == CNT_W'(depth_p));
      empty_r <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_r] <= in_dat;
    end
  end

endmodule

// File: rtl/uart_cmd_decoder.sv
// Purpose: assemble UART RX bytes into command words, match ON/OFF codes per channel, echo bytes to TX.
// Latency: last-byte handshake in cycle N -> led_o/match_o updated in cycle N+2; echo byte valid the cycle after acceptance.
// Backpressure: s_axis_tready_o = !echo_full (registered) and low during the one-cycle match state.
//
// Ports:
//   clk_i, reset_ni                          clock, synchronous active-low reset
//   s_axis_tdata_i/tvalid_i/tready_o         received byte stream (8 bit)
//   m_axis_tdata_o/tvalid_o/tready_i         echo byte stream to UART TX
//   led_o[channels_p]                        latched channel states
//   match_o                                  one-cycle pulse when a word hit any code
//   drop_count_o[8]                          saturating count of timed-out partial words
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int word_bytes_p = 4,
  parameter int channels_p   = 5,
  parameter logic [channels_p*word_bytes_p*BYTE_W-1:0] on_codes_p =
    (channels_p*word_bytes_p*BYTE_W)'(make_codes(64'(DEF_ON_CODE), channels_p, word_bytes_p*BYTE_W)),
  parameter logic [channels_p*word_bytes_p*BYTE_W-1:0] off_codes_p =
    (channels_p*word_bytes_p*BYTE_W)'(make_codes(64'(DEF_OFF_CODE), channels_p, word_bytes_p*BYTE_W)),
  parameter int echo_depth_p = 8,
  parameter int timeout_p    = 1000000
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic [BYTE_W-1:0]     s_axis_tdata_i,
  input  logic                  s_axis_tvalid_i,
  output logic                  s_axis_tready_o,
  output logic [BYTE_W-1:0]     m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic [channels_p-1:0] led_o,
  output logic                  match_o,
  output logic [DROP_W-1:0]     drop_count_o
);

  localparam int WORD_W  = word_bytes_p * BYTE_W;
  localparam int CNT_W   = $clog2(word_bytes_p + 1);
  localparam int IDLE_W  = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
  localparam bit TIMEOUT_EN = (timeout_p != 0);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(word_bytes_p - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(timeout_p - 1);

  logic [0:0]            state_r;
  logic [CNT_W-1:0]      byte_cnt_r;
  logic [IDLE_W-1:0]     idle_r;
  logic [WORD_W-1:0]     word_r;
  logic [WORD_W-1:0]     word_nxt;
  logic [channels_p-1:0] led_r;
  logic                  match_r;
  logic [DROP_W-1:0]     drop_cnt_r;
  logic [channels_p-1:0] on_hit;
  logic [channels_p-1:0] off_hit;
  logic                  fifo_in_rdy;
  logic                  accept;
  logic [CNT_W+2:0]      byte_shift;

  // Ready depends only on registered state, never on m_axis_tready_i.
  assign s_axis_tready_o = fifo_in_rdy && (state_r == ST_COLLECT);
  assign accept          = s_axis_tvalid_i && s_axis_tready_o;

  assign led_o        = led_r;
  assign match_o      = match_r;
  assign drop_count_o = drop_cnt_r;

  // Little-endian assembly: byte i lands at bit offset 8*i. Stale bytes of a
  // discarded partial word are simply overwritten by the next word.
  assign byte_shift = {byte_cnt_r, 3'b000};
  always_comb begin
    word_nxt = word_r;
    word_nxt = (word_nxt & ~(WORD_W'(8'hFF) << byte_shift))
             | (WORD_W'(s_axis_tdata_i) << byte_shift);
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      word_r <= word_nxt;
    end
  end

  for (genvar c = 0; c < channels_p; c++) begin : g_match
    assign on_hit[c]  = (word_r == on_codes_p[c*WORD_W +: WORD_W]);
    assign off_hit[c] = (word_r == off_codes_p[c*WORD_W +: WORD_W]);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_r    <= ST_COLLECT;
      byte_cnt_r <= '0;
      idle_r     <= '0;
      led_r      <= '0;
      match_r    <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      match_r <= 1'b0;
      case (state_r)
        ST_COLLECT: begin
          if (accept) begin
            idle_r <= '0;
            if (byte_cnt_r == LAST_BYTE) begin
              byte_cnt_r <= '0;
              state_r    <= ST_MATCH;
            end else begin
              byte_cnt_r <= byte_cnt_r + CNT_W'(1);
            end
          end else if (TIMEOUT_EN && (byte_cnt_r != '0)) begin
            // Idle only counts while a word is partially assembled.
            if (idle_r == IDLE_LAST) begin
              byte_cnt_r <= '0;
              idle_r     <= '0;
              if (drop_cnt_r != '1) begin
                drop_cnt_r <= drop_cnt_r + DROP_W'(1);
              end
            end else begin
              idle_r <= idle_r + IDLE_W'(1);
            end
          end
        end
        default: begin
          // OFF is applied after ON so it wins when a word hits both.
          led_r   <= (led_r | on_hit) & ~off_hit;
          match_r <= |(on_hit | off_hit);
          state_r <= ST_COLLECT;
        end
      endcase
    end
  end

  uart_cmd_fifo #(
    .depth_p(echo_depth_p),
    .width_p(BYTE_W)
  ) u_echo_fifo (
    .clk_i   (clk_i),
    .reset_ni(reset_ni),
    .in_dat  (s_axis_tdata_i),
    .in_vld  (accept),
    .in_rdy  (fifo_in_rdy),
    .out_dat (m_axis_tdata_o),
    .out_vld (m_axis_tvalid_o),
    .out_rdy (m_axis_tready_i)
  );

endmodule

// File: tb/tb_uart_cmd_decoder.sv
module tb_uart_cmd_decoder;

  logic       clk_i = 1'b0;
  logic       reset_ni;
  always #5 clk_i = ~clk_i;

  // Main instance: 4-byte words, 5 channels, default codes, short timeout.
  logic [7:0] s_tdata;
  logic       s_tvalid;
  wire        s_tready;
  wire  [7:0] m_tdata;
  wire        m_tvalid;
  logic       m_tready;
  wire  [4:0] led;
  wire        match;
  wire  [7:0] drop;

  // Second instance: 2-byte words, 2 channels, custom codes.
  logic [7:0] s2_tdata;
  logic       s2_tvalid;
  wire        s2_tready;
  wire  [7:0] m2_tdata;
  wire        m2_tvalid;
  logic       m2_tready;
  wire  [1:0] led2;
  wire        match2;
  wire  [7:0] drop2;

  uart_cmd_decoder #(
    .word_bytes_p(4), .channels_p(5), .echo_depth_p(8), .timeout_p(50)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axis_tdata_i(s_tdata), .s_axis_tvalid_i(s_tvalid), .s_axis_tready_o(s_tready),
    .m_axis_tdata_o(m_tdata), .m_axis_tvalid_o(m_tvalid), .m_axis_tready_i(m_tready),
    .led_o(led), .match_o(match), .drop_count_o(drop)
  );

  uart_cmd_decoder #(
    .word_bytes_p(2), .channels_p(2),
    .on_codes_p(32'h5678_1234), .off_codes_p(32'h9ABC_1234),
    .echo_depth_p(8), .timeout_p(50)
  ) dut2 (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .s_axis_tdata_i(s2_tdata), .s_axis_tvalid_i(s2_tvalid), .s_axis_tready_o(s2_tready),
    .m_axis_tdata_o(m2_tdata), .m_axis_tvalid_o(m2_tvalid), .m_axis_tready_i(m2_tready),
    .led_o(led2), .match_o(match2), .drop_count_o(drop2)
  );

  int         checks = 0;
  int         errors = 0;
  int         match_cnt = 0;
  int         mc;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always @(negedge clk_i) begin
    if (m_tvalid && m_tready) got_q.push_back(m_tdata);
    if (match) match_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the accepting posedge.
  task automatic send(input int which, input logic [7:0] b);
    int n;
    n = 0;
    if (which == 0) begin s_tdata = b; s_tvalid = 1'b1; end
    else            begin s2_tdata = b; s2_tvalid = 1'b1; end
    while (((which == 0) ? !s_tready : !s2_tready) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $error("FAIL send_stall byte=0x%0h observed=stalled expected=accepted", b);
    end else begin
      @(negedge clk_i);
      if (which == 0) exp_q.push_back(b);
    end
    if (which == 0) s_tvalid = 1'b0;
    else            s2_tvalid = 1'b0;
  endtask

  task automatic send_word(input int which, input logic [31:0] w, input int nb);
    for (int i = 0; i < nb; i++) send(which, 8'(w >> (8 * i)));
  endtask

  // Checks the two-cycle result latency of the word just sent to dut.
  task automatic word_result(input string tag, input logic [4:0] old_led,
                             input logic [4:0] new_led, input logic exp_match);
    chk({tag, "_led_n1"}, 32'(led), 32'(old_led));
    chk({tag, "_match_n1"}, 32'(match), 32'd0);
    @(negedge clk_i);
    chk({tag, "_led_n2"}, 32'(led), 32'(new_led));
    chk({tag, "_match_n2"}, 32'(match), 32'(exp_match));
    @(negedge clk_i);
    chk({tag, "_match_n3"}, 32'(match), 32'd0);
  endtask

  task automatic check_echo(input string tag);
    int n;
    n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(negedge clk_i);
      n++;
    end
    repeat (4) @(negedge clk_i);
    chk({tag, "_echo_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_echo_%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_ni = 1'b0;
    s_tdata = 8'h00; s_tvalid = 1'b0; m_tready = 1'b1;
    s2_tdata = 8'h00; s2_tvalid = 1'b0; m2_tready = 1'b1;
    repeat (3) @(negedge clk_i);
    reset_ni = 1'b1;
    @(negedge clk_i);

    // Reset state
    chk("rst_led", 32'(led), 32'd0);
    chk("rst_match", 32'(match), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    chk("rst_mvalid", 32'(m_tvalid), 32'd0);
    chk("rst_sready", 32'(s_tready), 32'd1);

    // ON code channel 0
    send_word(0, 32'h00B835F2, 4);
    word_result("t1", 5'b00000, 5'b00001, 1'b1);
    check_echo("t1");

    // OFF code channel 0, then ON code channel 1
    send_word(0, 32'hC0C0FFEE, 4);
    word_result("t2off", 5'b00001, 5'b00000, 1'b1);
    send_word(0, 32'h00B835F3, 4);
    word_result("t2on1", 5'b00000, 5'b00010, 1'b1);
    check_echo("t2");

    // Timeout discards a partial word after exactly 50 idle cycles
    mc = match_cnt;
    send(0, 8'hF2);
    send(0, 8'h35);
    repeat (49) @(negedge clk_i);
    chk("t3_drop_before", 32'(drop), 32'd0);
    @(negedge clk_i);
    chk("t3_drop_after", 32'(drop), 32'd1);
    send_word(0, 32'h35F200B8, 4);
    word_result("t3nomatch", 5'b00010, 5'b00010, 1'b0);
    chk("t3_match_count", 32'(match_cnt), 32'(mc));
    chk("t3_drop_hold", 32'(drop), 32'd1);
    send_word(0, 32'h00B835F2, 4);
    word_result("t3realign", 5'b00010, 5'b00011, 1'b1);
    check_echo("t3");

    // Echo backpressure: FIFO fills after 8 bytes
    m_tready = 1'b0;
    for (int i = 0; i < 8; i++) send(0, 8'(8'hA0 + i));
    repeat (2) @(negedge clk_i);
    chk("t4_sready_full", 32'(s_tready), 32'd0);
    chk("t4_mvalid", 32'(m_tvalid), 32'd1);
    chk("t4_mdata_head", 32'(m_tdata), 32'hA0);
    s_tdata = 8'hA8;
    s_tvalid = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("t4_sready_stuck", 32'(s_tready), 32'd0);
    chk("t4_mdata_stable", 32'(m_tdata), 32'hA0);
    m_tready = 1'b1;
    send(0, 8'hA8);
    send(0, 8'hA9);
    check_echo("t4");
    // Leftover A8,A9 partial word times out
    repeat (60) @(negedge clk_i);
    chk("t4_drop2", 32'(drop), 32'd2);

    // Second configuration: shared ON/OFF code on channel 0, OFF wins
    send_word(1, 32'h00001234, 2);
    @(negedge clk_i);
    chk("t5_led_both", 32'(led2), 32'd0);
    chk("t5_match_both", 32'(match2), 32'd1);
    send_word(1, 32'h00005678, 2);
    @(negedge clk_i);
    chk("t5_led_on1", 32'(led2), 32'b10);
    chk("t5_match_on1", 32'(match2), 32'd1);
    send_word(1, 32'h00009ABC, 2);
    @(negedge clk_i);
    chk("t5_led_off1", 32'(led2), 32'd0);
    @(negedge clk_i);
    chk("t5_match_end", 32'(match2), 32'd0);

    // Reset mid-word with echo bytes pending
    m_tready = 1'b0;
    send(0, 8'hF2);
    send(0, 8'h35);
    reset_ni = 1'b0;
    @(negedge clk_i);
    reset_ni = 1'b1;
    exp_q.delete();
    got_q.delete();
    chk("t6_mvalid", 32'(m_tvalid), 32'd0);
    chk("t6_sready", 32'(s_tready), 32'd1);
    chk("t6_led", 32'(led), 32'd0);
    chk("t6_drop", 32'(drop), 32'd0);
    m_tready = 1'b1;
    send_word(0, 32'h00B835F2, 4);
    word_result("t6", 5'b00000, 5'b00001, 1'b1);
    check_echo("t6");
    chk("t6_dut2_drop", 32'(drop2), 32'd0);
    chk("t6_dut2_mvalid", 32'(m2_tvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
